// File: rtl/display_pkg.sv
// Shared definitions for the display scan multiplexer: width helper,
// the all-off anode pattern and the channel-index type.
package display_pkg;

  localparam int MAX_CHANNELS = 16;

  // Anodes are active-low, so "all off" is all ones; users slice to CHANNELS.
  localparam logic [MAX_CHANNELS-1:0] ANODE_OFF = '1;

  typedef logic [3:0] ch_idx_t;

  // Bits needed to hold values 0..n-1; never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Dwell prescaler: counts 0..REFRESH_DIV-1 while not held, flags the terminal
// count as tick, and exposes the count the next edge will load.
module scan_prescaler
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CW          = clog2(REFRESH_DIV)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hold,
  output logic          tick,
  output logic [CW-1:0] count_nxt
);

  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] count;

  assign tick = !hold && (count == LAST);

  // NOTE: assign a default at the top of every always_comb so no path leaves
  // the output unassigned; a missed branch would otherwise infer a latch.
  always_comb begin
    count_nxt = count;
    if (!hold) count_nxt = (count == LAST) ? '0 : count + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count <= '0;
    else        count <= count_nxt;
  end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed display scanner: dwells REFRESH_DIV cycles per enabled
// channel, drives one active-low anode after a blanking window, and registers
// the selected code. Define DISPLAY_SCAN_MUX_LZ_BLANK_EN for leading-zero blanking.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int WIDTH        = 5,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2,
  parameter int SW           = clog2(CHANNELS),
  parameter int CW           = clog2(REFRESH_DIV)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [CHANNELS-1:0]       ch_en,
  output logic [WIDTH-1:0]          out,
  output logic [SW-1:0]             sel,
  output logic [CHANNELS-1:0]       anode,
  output logic                      strobe
);

  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);

  logic                tick;
  logic [CW-1:0]       cnt_nxt;
  logic [SW-1:0]       sel_srch;
  logic [SW-1:0]       sel_nxt;
  logic [SW-1:0]       cand;
  logic [CHANNELS-1:0] anode_nxt;
  logic                lz_blank;
  logic [WIDTH-1:0]    codes [CHANNELS];

  scan_prescaler #(
    .REFRESH_DIV(REFRESH_DIV),
    .CW         (CW)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .hold     (!enable),
    .tick     (tick),
    .count_nxt(cnt_nxt)
  );

  for (genvar k = 0; k < CHANNELS; k++) begin : g_codes
    assign codes[k] = in[k*WIDTH +: WIDTH];
  end

  // Nearest enabled channel above sel (wrapping); scanning from the far end
  // down lets the closest candidate win. Falls back to sel when none exists.
  always_comb begin
    sel_srch = sel;
    cand     = '0;
    for (int d = CHANNELS - 1; d >= 1; d--) begin
      cand = SW'((int'(sel) + d) % CHANNELS);
      if (ch_en[cand]) sel_srch = cand;
    end
  end

  assign sel_nxt = tick ? sel_srch : sel;

`ifdef DISPLAY_SCAN_MUX_LZ_BLANK_EN
  logic [CHANNELS-1:0] lz;

  // A channel is a leading zero when it and every higher channel code is 0.
  assign lz[0] = 1'b0;
  for (genvar k = 1; k < CHANNELS; k++) begin : g_lz
    assign lz[k] = (in[CHANNELS*WIDTH-1 : k*WIDTH] == '0);
  end

  assign lz_blank = lz[sel_nxt];
`else
  assign lz_blank = 1'b0;
`endif

  // Anode is decided from the values the next edge loads, so the drive
  // lines up with the new sel and count rather than lagging a cycle.
  always_comb begin
    anode_nxt = ANODE_OFF[CHANNELS-1:0];
    if (enable && ch_en[sel_nxt] && (cnt_nxt >= BLANK_C) && !lz_blank)
      anode_nxt[sel_nxt] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel    <= '0;
      out    <= '0;
      anode  <= ANODE_OFF[CHANNELS-1:0];
      strobe <= 1'b0;
    end else begin
      sel    <= sel_nxt;
      strobe <= tick;
      anode  <= anode_nxt;
      if (enable) out <= (|ch_en) ? codes[sel] : '0;
    end
  end

endmodule
